// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - edge strobes and period/lock monitor for a divided clock
module clk_div_monitor #(
  parameter int N        = 4,
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 3,
  parameter int TOL      = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clk_div_in,
  input  logic             enable,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             locked,
  output logic             err
);

  localparam int GOOD_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  N_C       = CNT_W'(N);
  localparam logic [CNT_W-1:0]  TWO_N     = CNT_W'(2 * N);
  localparam logic [CNT_W-1:0]  TOL_C     = CNT_W'(TOL);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ACQ, S_TRACK, S_LOCKED, S_ERR} state_t;

  state_t             state_q;
  logic               d1_q;
  logic               rise_pulse_q, fall_pulse_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   hcnt_q, hcnt_d;
  logic [CNT_W-1:0]   period_q, high_q;
  logic [GOOD_W-1:0]  good_q;
  logic               locked_q, err_q;

  logic               rise, fall, measuring, period_good, timeout;
  logic [CNT_W-1:0]   dev;

  always_comb begin
    rise        = clk_div_in & ~d1_q;
    fall        = ~clk_div_in & d1_q;
    measuring   = (state_q == S_TRACK) || (state_q == S_LOCKED) || (state_q == S_ERR);
    dev         = (cnt_q >= N_C) ? (cnt_q - N_C) : (N_C - cnt_q);
    period_good = (dev <= TOL_C);
    // A rise in the same cycle as the limit is a valid (long) period, not a stall.
    timeout     = (cnt_q >= TWO_N) && !rise;
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;
    if (rise) begin
      cnt_d  = CNT_W'(1);
      hcnt_d = CNT_W'(1);
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      if (clk_div_in && (hcnt_q != CNT_MAX)) hcnt_d = hcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      d1_q         <= 1'b0;
      rise_pulse_q <= 1'b0;
      fall_pulse_q <= 1'b0;
      cnt_q        <= '0;
      hcnt_q       <= '0;
      period_q     <= '0;
      high_q       <= '0;
      good_q       <= '0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      d1_q         <= clk_div_in;
      rise_pulse_q <= (state_q != S_IDLE) && rise;
      fall_pulse_q <= (state_q != S_IDLE) && fall;
      cnt_q        <= (state_q == S_IDLE) ? '0 : cnt_d;
      hcnt_q       <= (state_q == S_IDLE) ? '0 : hcnt_d;
      if (measuring && rise) period_q <= cnt_q;
      if (measuring && fall) high_q <= hcnt_q;

      if (!enable) begin
        state_q  <= S_IDLE;
        good_q   <= '0;
        locked_q <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            good_q  <= '0;
            state_q <= S_ACQ;
          end
          S_ACQ: begin
            if (rise) state_q <= S_TRACK;
          end
          S_TRACK: begin
            if (rise) begin
              if (!period_good) begin
                good_q <= '0;
              end else if (good_q == GOOD_LAST) begin
                good_q   <= '0;
                state_q  <= S_LOCKED;
                locked_q <= 1'b1;
              end else begin
                good_q <= good_q + GOOD_W'(1);
              end
            end else if (timeout) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
          S_LOCKED: begin
            if ((rise && !period_good) || timeout) begin
              state_q  <= S_ERR;
              locked_q <= 1'b0;
              err_q    <= 1'b1;
            end
          end
          S_ERR: begin
            state_q <= S_ERR;
          end
          default: begin
            state_q  <= S_IDLE;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rise_pulse = rise_pulse_q;
  assign fall_pulse = fall_pulse_q;
  assign period_cnt = period_q;
  assign high_cnt   = high_q;
  assign locked     = locked_q;
  assign err        = err_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - directed bench for clk_div_monitor (TOL=0 and TOL=1 instances)
module tb_clk_div_monitor;

  logic       clk = 1'b0;
  logic       rstn;
  logic       div_a, en_a, div_b, en_b;
  logic       rise_a, fall_a, lock_a, err_a;
  logic       rise_b, fall_b, lock_b, err_b;
  logic [7:0] per_a, high_a, per_b, high_b;
  logic       sel_tol;
  int         tests_run = 0;
  int         tests_failed = 0;

  always #5 clk = ~clk;

  clk_div_monitor #(.N(4), .CNT_W(8), .LOCK_CNT(3), .TOL(0)) u_dut (
    .clk(clk), .rstn(rstn), .clk_div_in(div_a), .enable(en_a),
    .rise_pulse(rise_a), .fall_pulse(fall_a), .period_cnt(per_a),
    .high_cnt(high_a), .locked(lock_a), .err(err_a)
  );

  clk_div_monitor #(.N(4), .CNT_W(8), .LOCK_CNT(3), .TOL(1)) u_dut_tol (
    .clk(clk), .rstn(rstn), .clk_div_in(div_b), .enable(en_b),
    .rise_pulse(rise_b), .fall_pulse(fall_b), .period_cnt(per_b),
    .high_cnt(high_b), .locked(lock_b), .err(err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v);
    if (sel_tol) div_b = v;
    else         div_a = v;
    @(posedge clk);
    #1;
  endtask

  task automatic period(input int hi, input int lo);
    for (int i = 0; i < hi; i++) step(1'b1);
    for (int i = 0; i < lo; i++) step(1'b0);
  endtask

  initial begin
    rstn = 1'b0; en_a = 1'b0; en_b = 1'b0; div_a = 1'b0; div_b = 1'b0; sel_tol = 1'b0;
    #3;
    check("rst_rise", rise_a, 0);
    check("rst_fall", fall_a, 0);
    check("rst_period", per_a, 0);
    check("rst_high", high_a, 0);
    check("rst_locked", lock_a, 0);
    check("rst_err", err_a, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Nominal divide-by-4 stream: lock on the 4th rise
    en_a = 1'b1;
    step(1'b0);
    step(1'b0);
    repeat (3) period(2, 2);
    check("s1_period", per_a, 4);
    check("s1_high", high_a, 2);
    check("s1_prelock", lock_a, 0);
    step(1'b1);
    check("s1_lock", lock_a, 1);
    check("s1_rise_pulse", rise_a, 1);
    step(1'b1);
    check("s1_rise_once", rise_a, 0);
    step(1'b0);
    check("s1_fall_pulse", fall_a, 1);
    step(1'b0);
    check("s1_fall_once", fall_a, 0);
    check("s1_err", err_a, 0);

    // Stuck low after lock: error exactly 8 clks after the last rise
    step(1'b1);
    step(1'b1);
    repeat (6) step(1'b0);
    check("s2_pre_err", err_a, 0);
    check("s2_pre_lock", lock_a, 1);
    step(1'b0);
    check("s2_err", err_a, 1);
    check("s2_unlock", lock_a, 0);
    repeat (5) step(1'b0);
    check("s2_err_sticky", err_a, 1);
    check("s2_lock_low", lock_a, 0);

    // One-cycle enable drop clears the error, then relock
    en_a = 1'b0;
    step(1'b0);
    check("s5_err_clr", err_a, 0);
    check("s5_period_kept", per_a, 4);
    en_a = 1'b1;
    step(1'b0);
    repeat (3) period(2, 2);
    check("s5_prelock", lock_a, 0);
    step(1'b1);
    check("s5_relock", lock_a, 1);
    step(1'b1);

    // Asynchronous reset while locked, mid high phase
    rstn = 1'b0;
    #2;
    check("s6_locked", lock_a, 0);
    check("s6_period", per_a, 0);
    check("s6_high", high_a, 0);
    check("s6_err", err_a, 0);
    div_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    step(1'b0);
    repeat (3) period(2, 2);
    check("s6_prelock", lock_a, 0);
    step(1'b1);
    check("s6_relock", lock_a, 1);
    check("s6_rise_pulse", rise_a, 1);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    check("s6_period_after", per_a, 4);
    check("s6_high_after", high_a, 2);

    // Period 6 with TOL=0: measured but never locks
    en_a = 1'b0;
    step(1'b0);
    en_a = 1'b1;
    step(1'b0);
    repeat (6) period(3, 3);
    check("s3_period", per_a, 6);
    check("s3_high", high_a, 3);
    check("s3_locked", lock_a, 0);
    check("s3_err", err_a, 0);

    // TOL=1: period 5 locks, a single period 7 errors at its closing rise
    sel_tol = 1'b1;
    en_b = 1'b1;
    step(1'b0);
    step(1'b0);
    repeat (3) period(3, 2);
    check("s4_prelock", lock_b, 0);
    step(1'b1);
    check("s4_lock", lock_b, 1);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    check("s4_period5", per_b, 5);
    check("s4_high3", high_b, 3);
    period(3, 4);
    check("s4_pre_err", err_b, 0);
    check("s4_still_lock", lock_b, 1);
    step(1'b1);
    check("s4_err", err_b, 1);
    check("s4_unlock", lock_b, 0);
    check("s4_period7", per_b, 7);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Sits directly downstream of clock_divider_byN. Consumes its clk_out, which is registered in the clk domain.
- Produces single-cycle rise/fall strobes that downstream logic uses as clock enables, so nothing is clocked on the divided clock.
- Measures the divided period and high time in clk cycles, and flags lock or error against the expected ratio N. This is the self-checking companion to the divider in the design and in its benches.

Parameters:
- N, 4, expected divide ratio; even, >=2.
- CNT_W, 8, width of the period and high-time counters; 2^CNT_W-1 must be >= 2*N.
- LOCK_CNT, 3, consecutive matching periods required to assert locked; >=1.
- TOL, 0, allowed |period - N| in clk cycles for a period to count as matching.

Ports:
- clk, input, 1, reference clock (same clk that drives the divider).
- rstn, input, 1, asynchronous active-low reset.
- clk_div_in, input, 1, divided clock; synchronous to clk, no synchronizer needed.
- enable, input, 1, monitor enable; low forces IDLE.
- rise_pulse, output, 1, one-cycle strobe per rising edge of clk_div_in.
- fall_pulse, output, 1, one-cycle strobe per falling edge of clk_div_in.
- period_cnt, output, CNT_W, last measured rise-to-rise period in clk cycles.
- high_cnt, output, CNT_W, last measured high time in clk cycles.
- locked, output, 1, LOCK_CNT consecutive matching periods seen.
- err, output, 1, sticky error: mismatch while locked, or stuck input.

Behaviour:
- Reset (rstn=0, asynchronous): all outputs 0, FSM in IDLE, all internal counters and sample registers 0.
- Edge detect:
  - d1 holds the previous sample of clk_div_in.
  - rise = clk_div_in & ~d1; fall = ~clk_div_in & d1.
  - rise_pulse and fall_pulse are registered: high for exactly one cycle, one clk after the sampling edge.
  - Strobes are generated in every state except IDLE.
- Period counter cnt:
  - Loads 1 on rise; otherwise increments each cycle.
  - Saturates at 2^CNT_W-1, with no wrap.
- High counter hcnt:
  - Loads 1 on rise; increments while clk_div_in=1.
  - On fall, high_cnt <= hcnt.
- Measurement: on each rise after the first since entering ACQ, period_cnt <= cnt. This is the value before reload, so an N=4 divider gives period 4 and high 2.
- Matching period: a period is "good" when |cnt - N| <= TOL at rise.
- FSM states IDLE, ACQ, TRACK, LOCKED, ERR:
  - IDLE: locked=0, err=0, good=0. Enters ACQ when enable=1.
  - ACQ: waits for the first rise, then goes to TRACK. Cnt starts counting. No timeout.
  - TRACK: on each rise:
    - good period: good++; when good reaches LOCK_CNT, go to LOCKED and set locked=1.
    - bad period: good=0, stay in TRACK.
  - LOCKED: a bad period -> ERR, locked=0, err=1.
  - ERR: err held; leaves only via enable=0 -> IDLE, which clears err.
- Timeout: in TRACK or LOCKED, if cnt reaches 2*N without a rise, go to ERR (stuck high or low).
  - From TRACK, a timeout also sets err=1.
- enable=0 in any state: next cycle goes to IDLE, locked=0, err=0. period_cnt and high_cnt retain their values.
- Simultaneous rise and timeout in the same cycle: the rise wins, and the period is evaluated normally.
- locked and err are never both 1.
- Reset mid-operation returns everything to reset values immediately, regardless of state.

Test Plan:
- Divider N=4 feeding clk_div_in, enable=1 after reset -> rise_pulse every 4 clks, fall_pulse 2 clks after each rise, period_cnt=4, high_cnt=2; locked=1 the cycle after the 4th rise (first rise plus 3 good periods); err=0.
- After lock, force clk_div_in=0 -> err=1 and locked=0 when cnt hits 8 clks after the last rise; err stays 1 with enable held at 1.
- Drive a period of 6 (3 high, 3 low), N=4, TOL=0 -> period_cnt=6, high_cnt=3, locked never asserts, err stays 0, FSM remains in TRACK.
- TOL=1 with period 5 -> locked after the 4th rise. Then a single period of 7 -> err=1 at that rise.
- In ERR, drop enable for 1 cycle and raise it again -> err=0 next cycle. Relocks after the 4th subsequent rise.
- Assert rstn=0 asynchronously while locked, mid-period -> all outputs 0 immediately without waiting for a clk edge. After release, behaviour matches the first scenario.
